// File: rtl/uart_debug_pkg.sv
// Shared constants and state encodings for the UART debug responder.
package uart_debug_pkg;

  // Command bytes accepted from the host.
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'

  // Reply bytes sent back when the reply is not read data.
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'

  // Frame-level protocol states.
  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_EXEC,
    ST_REPLY
  } frame_state_t;

  // Serial receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // True for the two command bytes that open a memory access frame.
  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE);
  endfunction

endpackage

// File: rtl/serial_byte_rx.sv
// 8N1 serial byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
module serial_byte_rx
  import uart_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Register the synchroniser chain and the receiver state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Walk start/data/stop bits, sampling the synchronised line mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line that is high again mid-start-bit was only a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          err_d   = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign stop_err   = err_q;

endmodule

// File: rtl/uart_debug_responder.sv
// Serial peek/poke responder: decodes R/W frames, performs one memory access, replies one byte.
module uart_debug_responder
  import uart_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CLKS - 1);

  logic       byte_valid, stop_err;
  logic [7:0] byte_data;

  frame_state_t  state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    reply_q, reply_d;
  logic          req_q, req_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_idx_q, tx_idx_d;
  logic          tx_active_q, tx_active_d;
  logic          tx_start, tx_done, timed, tmo_hit, drop;

  serial_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_CMD;
    else       state_q <= state_d;
  end

  // Datapath and transmitter registers; the tx shifter idles all-ones so tx rests high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      reply_q     <= '0;
      req_q       <= 1'b0;
      tmo_q       <= '0;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_active_q <= 1'b0;
    end else begin
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      reply_q     <= reply_d;
      req_q       <= req_d;
      tmo_q       <= tmo_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_active_q <= tx_active_d;
    end
  end

  // Next frame state plus the address/data/reply captures that ride along with it.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    reply_d    = reply_q;
    req_d      = req_q;
    // Inter-byte timer only counts while waiting for the rest of a frame.
    if (byte_valid)  tmo_d = '0;
    else if (timed)  tmo_d = tmo_q + 1'b1;
    else             tmo_d = '0;
    case (state_q)
      ST_CMD: begin
        if (byte_valid) begin
          if (is_command(byte_data)) begin
            is_write_d = (byte_data == CMD_WRITE);
            state_d    = ST_ADDR_HI;
          end else begin
            reply_d = RSP_BAD;
            state_d = ST_REPLY;
          end
        end
      end
      ST_ADDR_HI: begin
        if (byte_valid) begin
          addr_d[15:8] = byte_data;
          state_d      = ST_ADDR_LO;
        end else if (tmo_hit) begin
          state_d = ST_CMD;
        end
      end
      ST_ADDR_LO: begin
        if (byte_valid) begin
          addr_d[7:0] = byte_data;
          state_d     = is_write_q ? ST_DATA : ST_EXEC;
        end else if (tmo_hit) begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          wdata_d = byte_data;
          state_d = ST_EXEC;
        end else if (tmo_hit) begin
          state_d = ST_CMD;
        end
      end
      ST_EXEC: begin
        // An ack only counts once the request is actually on the port.
        if (req_q && mem_ack) begin
          req_d   = 1'b0;
          reply_d = is_write_q ? RSP_OK : mem_rdata;
          state_d = ST_REPLY;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_REPLY: begin
        if (tx_done) state_d = ST_CMD;
      end
      default: state_d = ST_CMD;
    endcase
    // A corrupted byte abandons a partially received frame.
    if (stop_err && (state_q inside {ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_DATA}))
      state_d = ST_CMD;
  end

  // Status outputs and the single-cycle strobes derived from the frame state.
  always_comb begin
    busy      = (state_q != ST_CMD);
    tx_start  = (state_q == ST_REPLY) && !tx_active_q;
    timed     = (state_q inside {ST_ADDR_HI, ST_ADDR_LO, ST_DATA});
    tmo_hit   = timed && !byte_valid && (tmo_q == TMO_M1);
    drop      = byte_valid && (state_q inside {ST_EXEC, ST_REPLY});
    frame_err = stop_err || drop || tmo_hit;
  end

  // Reply transmitter: load start/data/stop into a shifter and hold each bit one bit time.
  always_comb begin
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_active_d = tx_active_q;
    tx_done     = 1'b0;
    if (tx_start) begin
      tx_shift_d  = {1'b1, reply_q, 1'b0};
      tx_cnt_d    = '0;
      tx_idx_d    = '0;
      tx_active_d = 1'b1;
    end else if (tx_active_q) begin
      if (tx_cnt_q == BIT_M1) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_idx_q == 4'd9) begin
          tx_active_d = 1'b0;
          tx_done     = 1'b1;
        end else begin
          tx_idx_d = tx_idx_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  assign tx        = tx_shift_q[0];
  assign mem_req   = req_q;
  assign mem_we    = is_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_uart_debug_responder.sv
// Directed bench for uart_debug_responder: vector table of frames plus hand-written corner cases.
module tb_uart_debug_responder;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        tx;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, frame_err;

  uart_debug_responder #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .tx        (tx),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder controls and capture.
  logic       ack_hold = 1'b0;
  logic [7:0] rdata_cfg = 8'h00;
  int         acc_count = 0;
  logic [15:0] cap_addr;
  logic       cap_we;
  logic [7:0] cap_wdata;

  // Reply monitor.
  logic       mon_en = 1'b1;
  logic [7:0] rq [$];

  // Event bookkeeping.
  int          cyc = 0;
  int          ferr_count = 0;
  int          last_ferr_cyc = 0;
  int          last_addr_chg = 0;
  logic [15:0] prev_addr = 16'h0;

  typedef struct {
    logic [31:0] bytes;   // first byte in [31:24]
    int          nb;
    logic [7:0]  rdata;
    bit          acc;
    logic [15:0] addr;
    bit          we;
    logic [7:0]  wdata;
    logic [7:0]  reply;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_reply(output logic [7:0] got, output bit ok);
    got = 8'h00;
    ok  = 1'b0;
    for (int i = 0; i < 30 * CPB && rq.size() == 0; i++) @(negedge clk);
    if (rq.size() == 0) bound_fail("reply_wait");
    else begin
      got = rq.pop_front();
      ok  = 1'b1;
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 * CPB && !mem_req; i++) @(negedge clk);
    if (!mem_req) bound_fail("mem_req_wait");
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int acc0;
    logic [7:0] got;
    bit ok;
    rdata_cfg = v.rdata;
    acc0 = acc_count;
    for (int k = 0; k < v.nb; k++) send_byte(v.bytes[31 - 8 * k -: 8], 1'b1);
    wait_reply(got, ok);
    if (ok) check($sformatf("vec%0d_reply", idx), 32'(got), 32'(v.reply));
    check($sformatf("vec%0d_accesses", idx), 32'(acc_count - acc0), 32'(v.acc));
    if (v.acc) begin
      check($sformatf("vec%0d_addr", idx), 32'(cap_addr), 32'(v.addr));
      check($sformatf("vec%0d_we", idx), 32'(cap_we), 32'(v.we));
      if (v.we) check($sformatf("vec%0d_wdata", idx), 32'(cap_wdata), 32'(v.wdata));
    end
    check($sformatf("vec%0d_busy_after", idx), 32'(busy), 32'(0));
    $display("vec %0d: bytes %08h reply %02h accesses %0d", idx, v.bytes, got, acc_count - acc0);
  endtask

  // Memory port model: ack three cycles after the request is seen, unless held off.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      int req_wait;
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !ack_hold && !reset) begin
        if (req_wait == 2) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata_cfg;
          cap_addr  = mem_addr;
          cap_we    = mem_we;
          cap_wdata = mem_wdata;
          acc_count++;
          req_wait  = 0;
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
    end
  end

  // Cycle counter, frame_err pulses and address-update timestamps.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_err) begin
        ferr_count++;
        last_ferr_cyc = cyc;
      end
      if (mem_addr != prev_addr) last_addr_chg = cyc;
      prev_addr = mem_addr;
    end
  end

  // Serial reply decoder; also checks busy falls exactly as the stop bit ends.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("reply_start_bit", 32'(tx), 32'(0));
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("reply_stop_bit", 32'(tx), 32'(1));
        check("busy_mid_stop", 32'(busy), 32'(1));
        repeat (CPB / 2 - 1) @(negedge clk);
        check("busy_last_stop_cycle", 32'(busy), 32'(1));
        @(negedge clk);
        check("busy_after_stop", 32'(busy), 32'(0));
        rq.push_back(d);
      end
    end
  end

  initial begin
    int f0, a0;
    logic [7:0] got;
    bit ok;

    vecs[0] = '{32'h52901000, 3, 8'hA5, 1'b1, 16'h9010, 1'b0, 8'h00, 8'hA5};
    vecs[1] = '{32'h5780003C, 4, 8'h00, 1'b1, 16'h8000, 1'b1, 8'h3C, 8'h4B};
    vecs[2] = '{32'h41000000, 1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h3F};
    vecs[3] = '{32'h52000000, 3, 8'h5A, 1'b1, 16'h0000, 1'b0, 8'h00, 8'h5A};
    vecs[4] = '{32'h571234C3, 4, 8'h00, 1'b1, 16'h1234, 1'b1, 8'hC3, 8'h4B};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Table of complete frames.
    for (int i = 0; i < 5; i++) apply_vec(vecs[i], i);

    // Stop bit low on the second byte of a read: frame abandoned, nothing sent.
    f0 = ferr_count;
    a0 = acc_count;
    send_byte(8'h52, 1'b1);
    send_byte(8'h90, 1'b0);
    repeat (30 * CPB) @(negedge clk);
    check("stoperr_pulses", 32'(ferr_count - f0), 32'(1));
    check("stoperr_accesses", 32'(acc_count - a0), 32'(0));
    check("stoperr_replies", 32'(rq.size()), 32'(0));
    check("stoperr_busy", 32'(busy), 32'(0));
    $display("stop-bit error frame: frame_err pulses %0d", ferr_count - f0);

    // Short low glitch on idle line: no byte, no error.
    f0 = ferr_count;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_pulses", 32'(ferr_count - f0), 32'(0));
    check("glitch_busy", 32'(busy), 32'(0));
    $display("idle glitch: frame_err pulses %0d", ferr_count - f0);

    // Inter-byte timeout after 52 90.
    f0 = ferr_count;
    a0 = acc_count;
    send_byte(8'h52, 1'b1);
    send_byte(8'h90, 1'b1);
    for (int i = 0; i < TMO + 100 && ferr_count == f0; i++) @(negedge clk);
    if (ferr_count == f0) bound_fail("timeout_wait");
    else check("timeout_latency", 32'(last_ferr_cyc - last_addr_chg), 32'(TMO - 1));
    repeat (4) @(negedge clk);
    check("timeout_pulses", 32'(ferr_count - f0), 32'(1));
    check("timeout_busy", 32'(busy), 32'(0));
    check("timeout_addr_kept", 32'(mem_addr), 32'h9034);
    check("timeout_accesses", 32'(acc_count - a0), 32'(0));
    check("timeout_replies", 32'(rq.size()), 32'(0));
    $display("timeout: frame_err after %0d cycles", last_ferr_cyc - last_addr_chg + 1);
    apply_vec(vecs[0], 5);

    // Byte arriving during EXEC is dropped; the held access still completes.
    ack_hold  = 1'b1;
    rdata_cfg = 8'h77;
    a0 = acc_count;
    send_byte(8'h52, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    wait_req();
    check("exec_addr", 32'(mem_addr), 32'hABCD);
    check("exec_we", 32'(mem_we), 32'(0));
    f0 = ferr_count;
    send_byte(8'h52, 1'b1);
    check("exec_drop_pulse", 32'(ferr_count - f0), 32'(1));
    check("exec_req_held", 32'(mem_req), 32'(1));
    check("exec_busy", 32'(busy), 32'(1));
    ack_hold = 1'b0;
    wait_reply(got, ok);
    if (ok) check("exec_reply", 32'(got), 32'h77);
    check("exec_accesses", 32'(acc_count - a0), 32'(1));
    repeat (30 * CPB) @(negedge clk);
    check("exec_no_extra_reply", 32'(rq.size()), 32'(0));
    check("exec_idle_busy", 32'(busy), 32'(0));
    $display("exec drop: reply %02h accesses %0d", got, acc_count - a0);

    // Reset while a write request is pending: mem_req drops at once.
    ack_hold = 1'b1;
    send_byte(8'h57, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h99, 1'b1);
    wait_req();
    reset = 1'b1;
    #1;
    check("rstexec_mem_req", 32'(mem_req), 32'(0));
    check("rstexec_mem_we", 32'(mem_we), 32'(0));
    check("rstexec_mem_addr", 32'(mem_addr), 32'(0));
    check("rstexec_mem_wdata", 32'(mem_wdata), 32'(0));
    check("rstexec_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ack_hold = 1'b0;
    repeat (5) @(negedge clk);
    $display("reset during exec: mem_req %0d", mem_req);

    // Reset during the 5th data bit of a reply: tx returns high at once.
    mon_en    = 1'b0;
    ack_hold  = 1'b1;
    rdata_cfg = 8'h00;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_req();
    ack_hold = 1'b0;
    for (int i = 0; i < 10 * CPB && tx; i++) @(negedge clk);
    if (tx) bound_fail("reply_start_wait");
    else begin
      repeat (CPB / 2 + 5 * CPB) @(negedge clk);
      check("rsttx_bit4_low", 32'(tx), 32'(0));
      reset = 1'b1;
      #1;
      check("rsttx_tx", 32'(tx), 32'(1));
      check("rsttx_mem_req", 32'(mem_req), 32'(0));
      check("rsttx_busy", 32'(busy), 32'(0));
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    $display("reset during reply: tx %0d", tx);

    // Recovery after reset.
    apply_vec(vecs[1], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
